lc3b_line_responder: RTL and testbench
======================================

// Module: lc3b_line_responder
// PURPOSE
//   Memory-side responder for the LC-3b datapath's word port (mem_read/mem_write/mem_wmask).
//   Holds one 128-bit line (single-entry, write-back, write-allocate) and serves word/byte
//   accesses from it. Misses write the dirty line back to physical memory, then fill the new one.
//   Sits between the CPU memory stage and the 128-bit physical memory port.
// PARAMETERS
//   LINE_W   128  line width in bits (lc3b_line); fixed 8 words x 16 bits
//   ADDR_W   16   address width; tag = addr[15:4], word index = addr[3:1]
// PORTS
//   clk           in   1    single clock, all state updates on rising edge
//   reset_n       in   1    asynchronous, active-low reset
//   mem_read      in   1    CPU read request, held until mem_resp
//   mem_write     in   1    CPU write request, held until mem_resp
//   mem_wmask     in   2    byte enables: [0]=low byte (even addr), [1]=high byte
//   mem_address   in   16   CPU byte address; bit 0 ignored
//   mem_wdata     in   16   CPU write data
//   mem_resp      out  1    one-cycle completion pulse
//   mem_rdata     out  16   read data, valid while mem_resp=1
//   pmem_read     out  1    line fill request, held until pmem_resp
//   pmem_write    out  1    line writeback request, held until pmem_resp
//   pmem_address  out  16   line address, low 4 bits always 0
//   pmem_wdata    out  128  writeback line
//   pmem_rdata    in   128  fill line, valid when pmem_resp=1
//   pmem_resp     in   1    physical memory completion pulse
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, valid=0, dirty=0, tag=0, line=0; mem_resp=0,
//     mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
//   State: valid, dirty, tag[11:0], line[127:0]; word k = line[16k+15:16k].
//   FSM: IDLE, RESP, WRITEBACK, FILL.
//   IDLE: req = mem_read|mem_write. No req -> stay. hit = valid & tag==addr[15:4].
//     hit -> RESP; write merges mem_wdata bytes per mem_wmask into word addr[3:1], dirty<=1.
//     miss & valid & dirty -> WRITEBACK; miss otherwise -> FILL.
//     mem_read & mem_write together: treated as write.
//   RESP: mem_resp=1 and mem_rdata=word addr[3:1] (post-merge for writes) for exactly one
//     cycle; requests ignored; -> IDLE. Hit latency: request sampled cycle N, mem_resp in N+1.
//   WRITEBACK: pmem_write=1, pmem_address={tag,4'h0}, pmem_wdata=line, all stable until
//     pmem_resp; on pmem_resp -> FILL, dirty<=0.
//   FILL: pmem_read=1, pmem_address={mem_address[15:4],4'h0} stable until pmem_resp;
//     on pmem_resp: line<=pmem_rdata, tag<=addr[15:4], valid<=1, dirty<=0, -> IDLE
//     (request then hits; miss latency = WB + fill + 2 cycles).
//   pmem_read and pmem_write never both 1; pmem_resp outside WRITEBACK/FILL ignored.
//   CPU drops request mid-miss: transaction still completes, IDLE sees no req, no mem_resp.
//   mem_wmask=2'b00 write: hit path taken, no byte changes, dirty still set.
//   Reset mid-WRITEBACK/FILL: pmem_* deassert immediately; dirty data lost (accepted).
// TESTING
//   1 reset; read 0x1234; fill pmem_rdata word2=0xBEEF -> pmem_read addr 0x1230,
//     then single-cycle mem_resp with mem_rdata=0xBEEF.
//   2 then read 0x1236 -> mem_resp exactly 1 cycle after request, pmem_read stays 0.
//   3 write 0x1232 wdata 0xA5C3 wmask 2'b10 over 0x0011 -> read 0x1232 returns 0xA511.
//   4 then read 0x5670 -> pmem_write addr 0x1230 with merged line, then pmem_read 0x5670.
//   5 assert reset_n=0 during FILL -> pmem_read=0 same cycle; next read 0x1234 misses again.
//   6 hold pmem_resp low 10 cycles in FILL -> pmem_read/pmem_address stable all 10; mem_resp=0.

Source files
------------

// File: rtl/lc3b_line_responder.sv
// lc3b_line_responder
//   Memory-side responder for the LC-3b word port. Keeps one 128-bit line
//   (single entry, write-back, write-allocate) and serves word/byte accesses
//   from it. On a miss the dirty line is written back to physical memory and
//   then the requested line is filled.
//
//   Ports
//     clk, reset_n            clock, asynchronous active-low reset
//     mem_read / mem_write    CPU request, held until mem_resp
//     mem_wmask               byte enables ([0] low byte, [1] high byte)
//     mem_address / mem_wdata CPU byte address (bit 0 ignored) and write data
//     mem_resp / mem_rdata    one-cycle completion pulse and read data
//     pmem_read / pmem_write  line fill / writeback request, held until pmem_resp
//     pmem_address            line address (low 4 bits zero)
//     pmem_wdata / pmem_rdata writeback line / fill line
//     pmem_resp               physical memory completion pulse

// Byte-enable merge for one word of the line.
module lc3b_word_merge (
  input  logic        sel,
  input  logic [1:0]  wmask,
  input  logic [15:0] old_w,
  input  logic [15:0] wdata,
  output logic [15:0] new_w
);
  always_comb begin
    new_w = old_w;
    if (sel) begin
      if (wmask[0]) new_w[7:0]  = wdata[7:0];
      if (wmask[1]) new_w[15:8] = wdata[15:8];
    end
  end
endmodule

module lc3b_line_responder #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_wmask,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [15:0]       mem_wdata,
  output logic              mem_resp,
  output logic [15:0]       mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int WORDS = LINE_W / 16;
  localparam int IDX_W = $clog2(WORDS);
  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, RESP, WRITEBACK, FILL} state_t;

  state_t                       state_q, state_d;
  logic                         valid_q, valid_d;
  logic                         dirty_q, dirty_d;
  logic [TAG_W-1:0]             tag_q,   tag_d;
  logic [WORDS-1:0][15:0]       line_q,  line_d;
  // Word index of the hit being answered, so RESP does not depend on the
  // CPU keeping mem_address stable after the request was sampled.
  logic [IDX_W-1:0]             widx_q,  widx_d;
  // Tag of the line being fetched; latched so the fill address stays put
  // even if the CPU drops or changes its request mid-miss.
  logic [TAG_W-1:0]             mtag_q,  mtag_d;

  logic                         req;
  logic                         hit;
  logic [IDX_W-1:0]             a_idx;
  logic [TAG_W-1:0]             a_tag;
  logic [WORDS-1:0][15:0]       line_mrg;

  assign req   = mem_read | mem_write;
  assign a_idx = mem_address[IDX_W:1];
  assign a_tag = mem_address[ADDR_W-1:4];
  assign hit   = valid_q && (tag_q == a_tag);

  for (genvar k = 0; k < WORDS; k++) begin : g_word
    lc3b_word_merge u_merge (
      .sel   (a_idx == IDX_W'(k)),
      .wmask (mem_wmask),
      .old_w (line_q[k]),
      .wdata (mem_wdata),
      .new_w (line_mrg[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
      widx_q  <= '0;
      mtag_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      widx_q  <= widx_d;
      mtag_q  <= mtag_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    line_d  = line_q;
    widx_d  = widx_q;
    mtag_d  = mtag_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_d = RESP;
            widx_d  = a_idx;
            // Read+write together is a write; an all-zero mask still
            // marks the line dirty.
            if (mem_write) begin
              line_d  = line_mrg;
              dirty_d = 1'b1;
            end
          end else begin
            mtag_d  = a_tag;
            state_d = (valid_q && dirty_q) ? WRITEBACK : FILL;
          end
        end
      end
      RESP: state_d = IDLE;
      WRITEBACK: begin
        if (pmem_resp) begin
          dirty_d = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          tag_d   = mtag_q;
          valid_d = 1'b1;
          dirty_d = 1'b0;
          // Back to IDLE: the still-held request then hits.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state, so reset clears them immediately.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      RESP: begin
        mem_resp  = 1'b1;
        mem_rdata = line_q[widx_q];
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q, 4'h0};
        pmem_wdata   = line_q;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mtag_q, 4'h0};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lc3b_line_responder.sv
module tb_lc3b_line_responder;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]    mem_wmask = 2'b00;
  logic [15:0]   mem_address = '0, mem_wdata = '0;
  logic          mem_resp;
  logic [15:0]   mem_rdata;
  logic          pmem_read, pmem_write;
  logic [15:0]   pmem_address;
  logic [127:0]  pmem_wdata;
  logic [127:0]  pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  lc3b_line_responder dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference memory: CPU-visible word contents and physical-memory contents,
  // both keyed by word address, defaulting to a hash of the address.
  logic [15:0] ref_mem [int];
  logic [15:0] phys    [int];

  function automatic logic [15:0] init_word(int wa);
    logic [31:0] h;
    h = wa * 32'h9E3779B1;
    return h[31:16];
  endfunction
  function automatic logic [15:0] rd_ref(int wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction
  function automatic logic [15:0] rd_phys(int wa);
    return phys.exists(wa) ? phys[wa] : init_word(wa);
  endfunction
  function automatic logic [127:0] ref_line(int tag);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = rd_ref(tag*8 + k);
    return l;
  endfunction

  // Abstract model of the single resident line.
  bit m_valid = 0, m_dirty = 0;
  int m_tag = 0;

  typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } ptx_t;
  ptx_t        pq[$];
  logic [15:0] rq[$];
  int          fill_delay = -1;
  logic [15:0]  last_wb_addr = '0, last_fill_addr = '0;
  logic [127:0] last_wb_data = '0;

  task automatic model_access(input logic [15:0] addr, input bit wr, input logic [1:0] mask,
                              input logic [15:0] wdata, input bit want_resp, output bit hit);
    int tag, wa;
    logic [15:0] o;
    tag = int'(addr[15:4]);
    wa  = int'(addr[15:1]);
    hit = m_valid && (m_tag == tag);
    if (!hit) begin
      if (m_valid && m_dirty) pq.push_back('{1'b1, 16'(m_tag << 4), ref_line(m_tag)});
      pq.push_back('{1'b0, 16'(tag << 4), 128'h0});
      m_valid = 1; m_dirty = 0; m_tag = tag;
    end
    if (wr) begin
      o = rd_ref(wa);
      ref_mem[wa] = {mask[1] ? wdata[15:8] : o[15:8], mask[0] ? wdata[7:0] : o[7:0]};
      m_dirty = 1;
    end
    if (want_resp) rq.push_back(rd_ref(wa));
  endtask

  task automatic do_access(input logic [15:0] addr, input bit rd, input bit wr,
                           input logic [1:0] mask, input logic [15:0] wdata,
                           output logic [15:0] got);
    bit hit, done, saw_pmem;
    int n;
    @(posedge clk); #1;
    model_access(addr, wr, mask, wdata, 1'b1, hit);
    mem_address = addr; mem_read = rd; mem_write = wr; mem_wmask = mask; mem_wdata = wdata;
    n = 0; done = 0; saw_pmem = 0; got = '0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
      saw_pmem |= pmem_read | pmem_write;
      if (mem_resp) begin done = 1; got = mem_rdata; end
    end
    mem_read = 0; mem_write = 0;
    if (!done) chk("resp_timeout", 0, 1);
    if (hit) begin
      chk("hit_latency", n, 1);
      chk("hit_no_pmem", saw_pmem, 0);
    end
  endtask

  // Monitor: every mem_resp is matched against the next expected read value.
  initial forever begin
    @(negedge clk);
    if (reset_n && mem_resp) begin
      if (rq.size() == 0) chk("unexpected_mem_resp", 1, 0);
      else chk("mem_rdata", mem_rdata, rq.pop_front());
    end
  end

  // Physical memory responder and pmem-side scoreboard.
  initial forever begin
    ptx_t e;
    logic [15:0] ca;
    bit cw, aborted;
    int d;
    logic [127:0] l;
    @(negedge clk);
    if (reset_n && (pmem_read || pmem_write)) begin
      chk("pmem_exclusive", pmem_read & pmem_write, 0);
      ca = pmem_address; cw = pmem_write;
      if (pq.size() == 0) chk("unexpected_pmem", {cw, ca}, 0);
      else begin
        e = pq.pop_front();
        chk("pmem_kind", cw, e.wr);
        chk("pmem_address", ca, e.addr);
        if (e.wr) chk("pmem_wdata", pmem_wdata, e.data);
      end
      if (cw) begin last_wb_addr = ca; last_wb_data = pmem_wdata; end
      else last_fill_addr = ca;
      l = pmem_wdata;
      d = (fill_delay >= 0) ? fill_delay : int'($urandom_range(0, 3));
      aborted = 0;
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        if (!reset_n) begin aborted = 1; break; end
        chk("pmem_hold_addr", pmem_address, ca);
        chk("pmem_hold_req", {pmem_write, pmem_read}, {cw, !cw});
        chk("pmem_hold_no_resp", mem_resp, 0);
      end
      if (!aborted) begin
        @(posedge clk); #1;
        if (cw) for (int k = 0; k < 8; k++) phys[int'(ca[15:1]) + k] = l[16*k +: 16];
        else for (int k = 0; k < 8; k++) pmem_rdata[16*k +: 16] = rd_phys(int'(ca[15:1]) + k);
        pmem_resp = 1;
        @(posedge clk); #1;
        pmem_resp = 0; pmem_rdata = '0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] pool [5];
    bit hit;
    int n;
    pool = '{16'h1230, 16'h5670, 16'h9990, 16'h2000, 16'hABC0};

    // Reset state
    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;

    // 1: cold read miss, fill carries 0xBEEF in word 2
    phys[int'(16'h1234 >> 1)] = 16'hBEEF;
    ref_mem[int'(16'h1234 >> 1)] = 16'hBEEF;
    do_access(16'h1234, 1, 0, 2'b00, 16'h0, got);
    chk("t1_fill_addr", last_fill_addr, 16'h1230);
    chk("t1_rdata", got, 16'hBEEF);

    // 2: hit on same line
    do_access(16'h1236, 1, 0, 2'b00, 16'h0, got);

    // 3: byte-masked write merge
    do_access(16'h1232, 0, 1, 2'b11, 16'h0011, got);
    do_access(16'h1232, 0, 1, 2'b10, 16'hA5C3, got);
    chk("t3_write_resp", got, 16'hA511);
    do_access(16'h1232, 1, 0, 2'b00, 16'h0, got);
    chk("t3_read_back", got, 16'hA511);

    // Zero-mask write: no byte change, line still dirty (shows up as writeback)
    do_access(16'h123E, 1, 1, 2'b00, 16'hFFFF, got);

    // 4: dirty eviction
    do_access(16'h5670, 1, 0, 2'b00, 16'h0, got);
    chk("t4_wb_addr", last_wb_addr, 16'h1230);
    chk("t4_wb_word1", last_wb_data[31:16], 16'hA511);
    chk("t4_wb_word2", last_wb_data[47:32], 16'hBEEF);
    chk("t4_fill_addr", last_fill_addr, 16'h5670);

    // 5: reset during FILL
    @(posedge clk); #1;
    fill_delay = 30;
    model_access(16'h1234, 0, 2'b00, 16'h0, 1'b0, hit);
    mem_address = 16'h1234; mem_read = 1;
    n = 0;
    while (!pmem_read && n < 50) begin @(posedge clk); #1; n++; end
    chk("t5_fill_started", pmem_read, 1);
    repeat (3) @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("t5_rst_pmem_read", pmem_read, 0);
    chk("t5_rst_pmem_address", pmem_address, 0);
    chk("t5_rst_mem_resp", mem_resp, 0);
    mem_read = 0;
    m_valid = 0; m_dirty = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    fill_delay = -1;
    do_access(16'h1234, 1, 0, 2'b00, 16'h0, got);
    chk("t5_refill_addr", last_fill_addr, 16'h1230);
    chk("t5_rdata", got, 16'hBEEF);

    // CPU drops a read mid-miss: fill completes, no mem_resp
    @(posedge clk); #1;
    model_access(16'h9998, 0, 2'b00, 16'h0, 1'b0, hit);
    mem_address = 16'h9998; mem_read = 1;
    n = 0;
    while (!pmem_read && n < 50) begin @(posedge clk); #1; n++; end
    mem_read = 0;
    n = 0;
    while (pmem_read && n < 50) begin @(posedge clk); #1; n++; end
    chk("drop_fill_done", pmem_read, 0);
    repeat (5) begin @(negedge clk); chk("drop_no_resp", mem_resp, 0); end
    do_access(16'h999A, 1, 0, 2'b00, 16'h0, got);

    // 6: slow fill, stability checked in the responder over all 10 cycles
    fill_delay = 10;
    do_access(16'h2004, 1, 0, 2'b00, 16'h0, got);
    fill_delay = -1;

    // Randomized traffic over a few lines
    for (int t = 0; t < 150; t++) begin
      logic [15:0] a;
      int op;
      a = pool[$urandom_range(0, 4)] | 16'($urandom_range(0, 15));
      op = int'($urandom_range(0, 2));
      do_access(a, op != 1, op != 0, 2'($urandom_range(0, 3)), 16'($urandom), got);
    end

    repeat (10) @(negedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("pq_drained", pq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
